// File: rtl/event_ts_pkg.sv
// event_ts_pkg: shared status encoding and record layout for the event timestamper.
package event_ts_pkg;
  localparam int STATUS_W = 2;
  localparam int ID_W_DEF = 4;
  localparam int TS_W_DEF = 64;
  typedef enum logic [STATUS_W-1:0] {
    OK      = 2'd0,
    TIMEOUT = 2'd1
  } ts_status_e;
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [TS_W_DEF-1:0] start_ts;
    logic [TS_W_DEF-1:0] end_ts;
    logic [TS_W_DEF-1:0] delta;
    ts_status_e          status;
  } ts_record_t;
endpackage

// File: rtl/ts_record_fifo.sv
// ts_record_fifo: show-ahead FIFO over a packed record; output reads as zero while empty.
module ts_record_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full;
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/event_timestamper_tmo.sv
// event_timestamper_tmo: pairs start/end events by ID against a free-running counter,
// retires stale IDs via a round-robin timeout scanner and buffers records in a FIFO.
module event_timestamper_tmo
  import event_ts_pkg::*;
#(
  parameter int ID_W = 4,
  parameter int TS_W = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int TMO_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ID_W-1:0]   start_id,
  input  logic              end_valid,
  output logic              end_ready,
  input  logic [ID_W-1:0]   end_id,
  input  logic [TMO_W-1:0]  timeout_cycles,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [TS_W-1:0]   out_start_ts,
  output logic [TS_W-1:0]   out_end_ts,
  output logic [TS_W-1:0]   out_delta,
  output logic [1:0]        out_status,
  output logic [ID_W:0]     inflight,
  output logic [15:0]       drop_cnt
);
  localparam int DEPTH = 2 ** ID_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = ID_W + 3 * TS_W + STATUS_W;
  localparam int CW = TS_W > TMO_W ? TS_W : TMO_W;
  logic [TS_W-1:0] cnt;
  logic [DEPTH-1:0] active;
  logic [TS_W-1:0] ts_mem [DEPTH];
  logic [ID_W-1:0] scan_ptr;
  logic stg_valid;
  logic [ID_W-1:0] stg_id;
  logic [TS_W-1:0] stg_start, stg_end, scan_age;
  ts_status_e stg_status;
  logic [AW:0] fifo_count;
  logic [AW+1:0] occ;
  logic [RW-1:0] fifo_dout;
  logic fifo_empty, space, end_fire, end_hit, end_drop, start_fire, scan_go, retire, clr;
  assign occ = {1'b0, fifo_count} + {{(AW+1){1'b0}}, stg_valid};
  assign space = occ < (AW+2)'(FIFO_DEPTH);
  assign end_ready = space;
  assign end_fire = end_valid && space;
  assign end_hit = end_fire && active[end_id];
  assign end_drop = end_fire && !active[end_id];
  assign start_ready = !active[start_id] && !(end_fire && end_id == start_id);
  assign start_fire = start_valid && start_ready;
  // The scanner only runs in cycles where no end fires and a record slot is free.
  assign scan_go = !end_fire && space;
  assign scan_age = cnt - ts_mem[scan_ptr];
  assign retire = scan_go && timeout_cycles != '0 && active[scan_ptr] &&
                  CW'(scan_age) >= CW'(timeout_cycles);
  assign clr = end_hit || retire;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      active <= '0;
      scan_ptr <= '0;
      stg_valid <= 1'b0;
      stg_id <= '0;
      stg_start <= '0;
      stg_end <= '0;
      stg_status <= OK;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (scan_go) scan_ptr <= scan_ptr + 1'b1;
      if (start_fire) active[start_id] <= 1'b1;
      if (end_hit) active[end_id] <= 1'b0;
      if (retire) active[scan_ptr] <= 1'b0;
      stg_valid <= clr;
      if (clr) begin
        stg_id <= end_hit ? end_id : scan_ptr;
        stg_start <= end_hit ? ts_mem[end_id] : ts_mem[scan_ptr];
        stg_end <= cnt;
        stg_status <= end_hit ? OK : TIMEOUT;
      end
      inflight <= inflight + (ID_W+1)'(start_fire) - (ID_W+1)'(clr);
      if (end_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (start_fire) ts_mem[start_id] <= cnt;
  end
  ts_record_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stg_valid),
    .din   ({stg_id, stg_start, stg_end, stg_end - stg_start, stg_status}),
    .pop   (out_valid && out_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  assign out_valid = !fifo_empty;
  assign {out_id, out_start_ts, out_end_ts, out_delta, out_status} = fifo_dout;
endmodule

// File: tb/tb_event_timestamper_tmo.sv
// tb_event_timestamper_tmo: directed and randomized checks against a per-cycle
// behavioural model of the scoreboard, scanner and record queue (TS_W=8 build).
module tb_event_timestamper_tmo;
  localparam int ID_W = 4;
  localparam int TS_W = 8;
  localparam int FD = 8;
  localparam int TMO_W = 16;
  localparam int ND = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic start_valid, start_ready, end_valid, end_ready, out_valid, out_ready;
  logic [ID_W-1:0] start_id, end_id, out_id;
  logic [TMO_W-1:0] timeout_cycles;
  logic [TS_W-1:0] out_start_ts, out_end_ts, out_delta;
  logic [1:0] out_status;
  logic [ID_W:0] inflight;
  logic [15:0] drop_cnt;
  always #5 clk = ~clk;
  event_timestamper_tmo #(.ID_W(ID_W), .TS_W(TS_W), .FIFO_DEPTH(FD), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .start_id(start_id),
    .end_valid(end_valid), .end_ready(end_ready), .end_id(end_id),
    .timeout_cycles(timeout_cycles),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_start_ts(out_start_ts), .out_end_ts(out_end_ts), .out_delta(out_delta),
    .out_status(out_status), .inflight(inflight), .drop_cnt(drop_cnt)
  );
  typedef struct {int id; int st; int en; int status; int t;} rec_t;
  rec_t q[$];
  bit mact[ND];
  int mts[ND];
  int mcnt, cyc, mp, minfl, mdrop, tmo;
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    q.delete();
    foreach (mact[i]) mact[i] = 0;
    mcnt = 0; cyc = 0; mp = 0; minfl = 0; mdrop = 0;
  endtask
  // One clock cycle: drive, check against model, advance model, move to next negedge.
  task automatic step(input bit sv, input int sid, input bit ev, input int eid,
                      input bit ordy, output bit ef);
    bit space, sr, vis;
    start_valid = sv; start_id = ID_W'(sid);
    end_valid = ev; end_id = ID_W'(eid);
    out_ready = ordy;
    timeout_cycles = TMO_W'(tmo);
    #1;
    space = q.size() < FD;
    ef = ev && space;
    sr = !mact[sid] && !(ef && eid == sid);
    vis = q.size() > 0 && q[0].t + 2 <= cyc;
    chk("start_ready", start_ready, sr);
    chk("end_ready", end_ready, space);
    chk("out_valid", out_valid, vis);
    if (vis) begin
      chk("out_id", out_id, q[0].id);
      chk("out_start_ts", out_start_ts, q[0].st);
      chk("out_end_ts", out_end_ts, q[0].en);
      chk("out_delta", out_delta, (q[0].en - q[0].st + 256) % 256);
      chk("out_status", out_status, q[0].status);
    end
    chk("inflight", inflight, minfl);
    chk("drop_cnt", drop_cnt, mdrop);
    if (vis && ordy) void'(q.pop_front());
    if (ef) begin
      if (mact[eid]) begin
        q.push_back('{eid, mts[eid], mcnt, 0, cyc});
        mact[eid] = 0;
        minfl--;
      end else if (mdrop < 65535) mdrop++;
    end else if (space) begin
      if (tmo != 0 && mact[mp] && ((mcnt - mts[mp] + 256) % 256) >= tmo) begin
        q.push_back('{mp, mts[mp], mcnt, 1, cyc});
        mact[mp] = 0;
        minfl--;
      end
      mp = (mp + 1) % ND;
    end
    if (sv && sr) begin
      mts[sid] = mcnt;
      mact[sid] = 1;
      minfl++;
    end
    mcnt = (mcnt + 1) % 256;
    cyc++;
    @(negedge clk);
  endtask
  task automatic idle(input int n, input bit ordy);
    bit ef;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, ordy, ef);
  endtask
  task automatic wait_cnt(input int target, input bit ordy);
    bit ef;
    for (int i = 0; i < 300 && mcnt != target; i++) step(0, 0, 0, 0, ordy, ef);
    chk("wait_cnt_reached", 32'(mcnt), 32'(target));
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_inflight"}, inflight, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_out_id"}, out_id, 0);
    chk({tag, "_out_delta"}, out_delta, 0);
    chk({tag, "_out_status"}, out_status, 0);
  endtask
  initial begin
    bit ef, seen;
    int waits;
    rst_n = 1'b0;
    start_valid = 0; start_id = '0; end_valid = 0; end_id = '0;
    out_ready = 0; tmo = 0; timeout_cycles = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_start_ts", out_start_ts, 0);
    chk("reset_end_ts", out_end_ts, 0);
    rst_n = 1'b1;
    model_clear();
    // Basic pair: start ID 3 at cnt 10, end at cnt 25.
    wait_cnt(10, 1);
    step(1, 3, 0, 0, 1, ef);
    chk("t1_inflight_after_start", inflight, 1);
    wait_cnt(25, 1);
    step(0, 0, 1, 3, 0, ef);
    step(0, 0, 0, 0, 0, ef);
    chk("t1_valid", out_valid, 1);
    chk("t1_id", out_id, 3);
    chk("t1_start", out_start_ts, 10);
    chk("t1_end", out_end_ts, 25);
    chk("t1_delta", out_delta, 15);
    chk("t1_status", out_status, 0);
    chk("t1_inflight", inflight, 0);
    idle(3, 1);
    // Backpressure: nine pairs into an eight-deep buffer.
    for (int k = 0; k < 9; k++) step(1, k, 0, 0, 0, ef);
    for (int k = 0; k < 8; k++) step(0, 0, 1, k, 0, ef);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 8, 0, ef);
      chk("t2_ninth_end_waits", ef, 0);
    end
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step(0, 0, 1, 8, 1, ef);
      seen = ef;
    end
    chk("t2_ninth_end_fired", seen, 1);
    idle(14, 1);
    chk("t2_drained", out_valid, 0);
    // Timeout: start ID 5 at cnt 100 with a 20-cycle threshold.
    tmo = 20;
    wait_cnt(100, 1);
    step(1, 5, 0, 0, 1, ef);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        seen = 1;
        chk("t3_tmo_status", out_status, 1);
        chk("t3_tmo_id", out_id, 5);
        chk("t3_tmo_delta_range", (out_delta >= 20 && out_delta <= 20 + ND), 1);
      end
      step(0, 0, 0, 0, 1, ef);
    end
    chk("t3_tmo_seen", seen, 1);
    chk("t3_inflight", inflight, 0);
    step(0, 0, 1, 5, 1, ef);
    idle(1, 1);
    chk("t3_drop_cnt", drop_cnt, 1);
    tmo = 0;
    // Same-cycle start and end on an active ID.
    step(1, 7, 0, 0, 1, ef);
    step(1, 7, 1, 7, 1, ef);
    step(1, 7, 0, 0, 1, ef);
    chk("t4_inflight", inflight, 1);
    step(0, 0, 1, 7, 1, ef);
    idle(3, 1);
    // Counter wrap: start at 251, end at 4.
    wait_cnt(251, 1);
    step(1, 1, 0, 0, 1, ef);
    wait_cnt(4, 1);
    step(0, 0, 1, 1, 0, ef);
    step(0, 0, 0, 0, 0, ef);
    chk("t5_wrap_delta", out_delta, 9);
    chk("t5_wrap_start", out_start_ts, 251);
    idle(3, 1);
    // Randomized traffic with timeouts enabled.
    tmo = 30;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, ND - 1)),
           $urandom_range(0, 2) == 0, int'($urandom_range(0, ND - 1)),
           $urandom_range(0, 3) != 0, ef);
    tmo = 0;
    idle(20, 1);
    // Reset mid-operation: three active IDs and two queued records.
    for (int k = 10; k < 15; k++) step(1, k, 0, 0, 0, ef);
    step(0, 0, 1, 13, 0, ef);
    step(0, 0, 1, 14, 0, ef);
    idle(2, 0);
    chk("t7_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t7_async");
    @(negedge clk);
    check_reset_outputs("t7_next");
    rst_n = 1'b1;
    model_clear();
    idle(6, 1);
    chk("t7_no_stale", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/event_timestamper_tmo.md
# event_timestamper_tmo

Parametrised successor to the single-record event timestamper. It pairs start/end events by ID against a free-running timestamp counter and retires stale IDs through a configurable timeout scanner. Retired records go into an output FIFO, so several completions can be buffered under downstream backpressure. It sits between the packet-parse event sources and the UDP record packer.

## Interface
Parameters:
- ID_W, 4, event ID width; scoreboard depth DEPTH = 2**ID_W
- TS_W, 64, timestamp counter width
- FIFO_DEPTH, 8, output record FIFO depth; power of two, ≥2
- TMO_W, 16, timeout threshold width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_valid / start_ready / start_id  in/out/in  1/1/ID_W  start-event handshake
- end_valid / end_ready / end_id  in/out/in  1/1/ID_W  end-event handshake
- timeout_cycles  in  TMO_W  retire threshold; 0 disables timeouts; quasi-static
- out_valid / out_ready  out/in  1/1  record handshake
- out_id  out  ID_W  record ID
- out_start_ts  out  TS_W  timestamp captured at start
- out_end_ts  out  TS_W  timestamp at end, or at timeout detection
- out_delta  out  TS_W  out_end_ts − out_start_ts, modulo 2**TS_W
- out_status  out  2  record status: OK=0, TIMEOUT=1
- inflight  out  ID_W+1  number of active IDs
- drop_cnt  out  16  unmatched ends; saturates at 0xFFFF

## Operation
- Counter cnt increments every cycle and wraps at 2**TS_W. All differences are modulo 2**TS_W.
- Start:
  - start_ready = !active[start_id] && !(end_fire && end_id==start_id).
  - On fire: ts_mem[start_id]=cnt, active[start_id]=1.
- End:
  - end_ready = space, where space = (fifo_count + stage_valid) < FIFO_DEPTH.
  - On fire with active[end_id]=1: clear active[end_id] and load the stage register {id, ts_mem[end_id], cnt, OK}.
  - On fire with active[end_id]=0: accept, emit nothing, increment drop_cnt (saturating).
- Timeout scanner:
  - Pointer scan_ptr advances one ID per cycle, wrapping DEPTH−1→0.
  - Retire condition: timeout_cycles≠0 && active[scan_ptr] && (cnt − ts_mem[scan_ptr]) ≥ timeout_cycles.
  - On retire: load the stage register with {scan_ptr, ts_mem[scan_ptr], cnt, TIMEOUT} and clear active[scan_ptr].
  - Arbitration: end fire has priority. If end fires, or space is 0, the scanner holds scan_ptr and does not retire.
  - Start never conflicts with the scanner, because start needs the ID inactive and a retire needs it active.
- Stage register writes the FIFO on the next edge; the FIFO write computes delta. The FIFO is show-ahead: out_valid = !empty.
- inflight: +1 on start fire, −1 on active clear; both in the same cycle leave it unchanged.

## Timing
- Reset values: out_valid=0, out_id/out_start_ts/out_end_ts/out_delta=0, out_status=OK, inflight=0, drop_cnt=0, cnt=0, all active=0, FIFO empty, stage_valid=0, scan_ptr=0. ts_mem is not reset.
- Latency: end fire in cycle T → record visible with out_valid=1 in cycle T+2 (FIFO empty, no backpressure). A timeout retire has the same latency.
- Throughput: one record per cycle.
- out_* must hold stable while out_valid && !out_ready.
- Full FIFO: end_ready=0 and the scanner stalls; no record is lost or overwritten.
- Same cycle, same ID, start+end: end fires, start is stalled one cycle, and the ID re-starts next cycle at the new cnt.
- Re-start of an ID in the cycle after its end: allowed.
- Worst-case timeout detection delay beyond the threshold: DEPTH cycles plus stall cycles.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight records are discarded.

## Structure
- Package event_ts_pkg:
  - ts_status_e enum (OK, TIMEOUT)
  - ts_record_t struct, parametrised via localparam defaults
  - STATUS_W=2
- Sub-module ts_record_fifo: synchronous show-ahead FIFO, async active-low reset, generic over the packed record width. Pointers are log2(FIFO_DEPTH)+1 bits for full/empty.
- Top-level holds the counter, scoreboard (ts_mem, active), scanner, stage register and drop/inflight counters.

## Test plan
- Start ID 3 at cnt=10, end ID 3 at cnt=25 → one record {id=3, start=10, end=25, delta=15, OK} two cycles after end fire; inflight 1→0.
- out_ready=0, fire 9 start/end pairs with FIFO_DEPTH=8 → end_ready drops after 8 buffered; the 9th end waits; all 9 records drain in order once out_ready=1.
- timeout_cycles=20, start ID 5 at cnt=100, no end → TIMEOUT record with id=5, delta in [20, 20+DEPTH]; active[5] cleared; a later end on ID 5 increments drop_cnt to 1.
- Start and end both on ID 7 in one cycle while ID 7 is active → end fires, start_ready=0 that cycle; start fires next cycle; inflight unchanged net.
- Preload cnt near 2**TS_W−5 (TS_W=8 build): start at 251, end at 4 → delta=9.
- Assert rst_n low with 3 active IDs and 2 queued records → out_valid=0, inflight=0, drop_cnt=0 on the following cycle; no stale record after release.
